// File: rtl/gcd_unit_iterative.sv
// Iterative Euclid GCD unit: accepts one packed {A,B} request, reduces it by
// swap/subtract steps (one per cycle), then holds the result until the sink
// takes it. Only one request is in flight at a time.
module gcd_unit_iterative #(
    parameter int unsigned p_nbits = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [2*p_nbits-1:0]   req_msg,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic [p_nbits-1:0]     resp_msg,
    output logic                   busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [p_nbits-1:0] a_reg;
    logic [p_nbits-1:0] b_reg;
    logic [p_nbits-1:0] a_next;
    logic [p_nbits-1:0] b_next;

    // Next-state and datapath step; req_msg is only looked at on an accepted request.
    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        case (state)
            IDLE: begin
                if (req_val && req_rdy) begin
                    a_next     = req_msg[2*p_nbits-1:p_nbits];
                    b_next     = req_msg[p_nbits-1:0];
                    state_next = CALC;
                end
            end
            CALC: begin
                if (a_reg < b_reg) begin
                    a_next = b_reg;
                    b_next = a_reg;
                end else if (b_reg != '0) begin
                    a_next = a_reg - b_reg;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (resp_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and operand registers; reset discards any in-flight computation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            state <= state_next;
            a_reg <= a_next;
            b_reg <= b_next;
        end
    end

    assign req_rdy  = (state == IDLE);
    assign resp_val = (state == DONE);
    assign busy     = (state != IDLE);
    assign resp_msg = a_reg;

endmodule
